// File: rtl/systolic_core_q_if.sv
// Activation/weight/result bundle for systolic_core_q.
// The master drives vectors and weights; the slave is the core.
interface systolic_core_q_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 32
);
    logic                 w_load;
    logic signed [DW-1:0] weights [N][N];
    logic                 a_valid;
    logic                 a_ready;
    logic                 a_last;
    logic signed [DW-1:0] activation [N];
    logic [4:0]           q_shift;
    logic                 out_valid;
    logic signed [AW-1:0] result_raw [N];
    logic signed [DW-1:0] result_q [N];
    logic                 busy;
    logic                 done;

    modport master (
        output w_load, weights, a_valid, a_last, activation, q_shift,
        input  a_ready, out_valid, result_raw, result_q, busy, done
    );

    modport slave (
        input  w_load, weights, a_valid, a_last, activation, q_shift,
        output a_ready, out_valid, result_raw, result_q, busy, done
    );
endinterface

// File: rtl/systolic_core_q.sv
// Weight-stationary N x N systolic matrix-vector core with skew/deskew buffers,
// rounding requantisation and saturation; one result vector per accepted vector.
module systolic_core_q #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 32
) (
    input logic              clk,
    input logic              reset,
    systolic_core_q_if.slave bus
);
    localparam int unsigned Lat  = 2 * N;
    localparam int          QMax = (1 << (DW - 1)) - 1;
    localparam int          QMin = -(1 << (DW - 1));

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e               state_q, state_d;
    logic                 accept, a_ready, done_d, done_q;
    logic                 out_valid_q, out_last_q;
    logic [Lat-2:0]       vld_q, last_q;
    logic [4:0]           shift_q [Lat-1];
    logic signed [DW-1:0] w_q [N][N];
    logic signed [DW-1:0] wt [N][N];
    logic signed [DW-1:0] lane_in [N];
    logic signed [DW-1:0] skew_out [N];
    logic signed [DW-1:0] act_q [N][N-1];
    logic signed [AW-1:0] ps_q [N][N];
    logic signed [AW-1:0] col_out [N];
    logic signed [AW-1:0] res_raw_q [N];
    logic signed [DW-1:0] res_q_q [N];

    function automatic logic signed [DW-1:0] requant(input logic signed [AW-1:0] acc,
                                                     input logic [4:0] s);
        logic signed [AW:0] ext, rnd, r;
        ext = (AW+1)'(acc);
        rnd = '0;
        if (s != 5'd0) rnd[s - 5'd1] = 1'b1;
        r = (ext + rnd) >>> s;
        if (r > (AW+1)'(QMax))      requant = DW'(QMax);
        else if (r < (AW+1)'(QMin)) requant = DW'(QMin);
        else                        requant = DW'(r);
    endfunction

    always_comb begin
        state_d = state_q;
        a_ready = (state_q != StDrain);
        accept  = bus.a_valid && a_ready;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle:   if (accept) state_d = bus.a_last ? StDrain : StStream;
            StStream: if (accept && bus.a_last) state_d = StDrain;
            StDrain: begin
                if (out_valid_q && out_last_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) w_q[i][j] <= '0;
        end else if (state_q == StIdle && bus.w_load) begin
            w_q <= bus.weights;
        end
    end

    // Row 0 sees a vector in its acceptance cycle, so it bypasses a same-cycle load.
    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wt[i][j] = w_q[i][j];
        if (state_q == StIdle && bus.w_load)
            for (int j = 0; j < N; j++) wt[0][j] = bus.weights[0][j];
        for (int i = 0; i < N; i++) lane_in[i] = accept ? bus.activation[i] : '0;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign skew_out[gi] = lane_in[gi];
        end else begin : g_delay
            logic signed [DW-1:0] sr [gi];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < gi; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= lane_in[gi];
                    for (int k = 1; k < gi; k++) sr[k] <= sr[k-1];
                end
            end
            assign skew_out[gi] = sr[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic signed [DW-1:0]   a_in;
            logic signed [AW-1:0]   p_in;
            logic signed [2*DW-1:0] prod;
            if (gj == 0) begin : g_a_edge
                assign a_in = skew_out[gi];
            end else begin : g_a_chain
                assign a_in = act_q[gi][gj-1];
            end
            if (gi == 0) begin : g_p_edge
                assign p_in = '0;
            end else begin : g_p_chain
                assign p_in = ps_q[gi-1][gj];
            end
            assign prod = a_in * wt[gi][gj];
            always_ff @(posedge clk) begin
                if (reset) ps_q[gi][gj] <= '0;
                else       ps_q[gi][gj] <= p_in + AW'(prod);
            end
            if (gj < N - 1) begin : g_fwd
                always_ff @(posedge clk) begin
                    if (reset) act_q[gi][gj] <= '0;
                    else       act_q[gi][gj] <= a_in;
                end
            end
        end
    end

    // Column j leaves the array N-1-j cycles before the last column.
    for (genvar gj = 0; gj < N; gj++) begin : g_deskew
        if (gj == N - 1) begin : g_direct
            assign col_out[gj] = ps_q[N-1][gj];
        end else begin : g_delay
            localparam int unsigned D = N - 1 - gj;
            logic signed [AW-1:0] sr [D];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < D; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= ps_q[N-1][gj];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            end
            assign col_out[gj] = sr[D-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int k = 0; k < Lat - 1; k++) shift_q[k] <= '0;
            for (int j = 0; j < N; j++) begin
                res_raw_q[j] <= '0;
                res_q_q[j]   <= '0;
            end
        end else begin
            vld_q       <= {vld_q[Lat-3:0], accept};
            last_q      <= {last_q[Lat-3:0], accept && bus.a_last};
            shift_q[0]  <= bus.q_shift;
            for (int k = 1; k < Lat - 1; k++) shift_q[k] <= shift_q[k-1];
            out_valid_q <= vld_q[Lat-2];
            out_last_q  <= last_q[Lat-2];
            if (vld_q[Lat-2]) begin
                for (int j = 0; j < N; j++) begin
                    res_raw_q[j] <= col_out[j];
                    res_q_q[j]   <= requant(col_out[j], shift_q[Lat-2]);
                end
            end
        end
    end

    assign bus.a_ready    = a_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.result_raw = res_raw_q;
    assign bus.result_q   = res_q_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_systolic_core_q.sv
// Randomised bench for systolic_core_q: a matrix-vector reference model predicts
// every result vector, its arrival cycle, the done pulse and a_ready.
module tb_systolic_core_q;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int LAT = 2 * N;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    systolic_core_q_if #(.N(N), .DW(DW), .AW(AW)) bus ();
    systolic_core_q #(.N(N), .DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DW-1:0] mw [N][N];
    logic signed [DW-1:0] nw [N][N];
    logic signed [DW-1:0] av [N];
    logic [4:0]           sv;
    int                   exp_cyc [$];
    logic signed [63:0]   exp_raw [$];
    logic signed [63:0]   exp_q [$];
    logic signed [63:0]   hold_raw [N];
    logic signed [63:0]   hold_q [N];
    bit                   draining = 0;
    int                   done_cyc = -1;
    bit                   mon_en = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Rounded right shift as floor((acc + d/2) / d), then clamp to DW bits.
    function automatic longint ref_q(input longint acc, input int s);
        longint r, d, lim;
        if (s == 0) begin
            r = acc;
        end else begin
            d = longint'(1) << s;
            r = acc + d / 2;
            r = (r >= 0) ? r / d : -((-r + d - 1) / d);
        end
        lim = longint'(1) << (DW - 1);
        if (r > lim - 1) r = lim - 1;
        else if (r < -lim) r = -lim;
        return r;
    endfunction

    always @(negedge clk) begin
        bit     exp_v;
        longint acc;
        if (mon_en) begin
            if (cyc == done_cyc) draining = 0;
            exp_v = (exp_cyc.size() > 0) && (exp_cyc[0] == cyc);
            check("out_valid", bus.out_valid, exp_v);
            check("done", bus.done, cyc == done_cyc);
            check("a_ready", bus.a_ready, !draining);
            if (exp_v) begin
                void'(exp_cyc.pop_front());
                for (int j = 0; j < N; j++) begin
                    hold_raw[j] = exp_raw.pop_front();
                    hold_q[j]   = exp_q.pop_front();
                end
            end
            for (int j = 0; j < N; j++) begin
                check("result_raw", bus.result_raw[j], hold_raw[j]);
                check("result_q", bus.result_q[j], hold_q[j]);
            end
            if (!reset && bus.a_valid && bus.a_ready) begin
                exp_cyc.push_back(cyc + LAT);
                for (int j = 0; j < N; j++) begin
                    acc = 0;
                    for (int i = 0; i < N; i++)
                        acc += longint'(bus.activation[i]) * longint'(mw[i][j]);
                    exp_raw.push_back(acc);
                    exp_q.push_back(ref_q(acc, int'(bus.q_shift)));
                end
                if (bus.a_last) begin
                    draining = 1;
                    done_cyc = cyc + LAT + 1;
                end
            end
            if (reset) begin
                exp_cyc.delete();
                exp_raw.delete();
                exp_q.delete();
                draining = 0;
                done_cyc = -1;
                for (int j = 0; j < N; j++) begin
                    hold_raw[j] = 0;
                    hold_q[j]   = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input bit model);
        bus.weights = nw;
        bus.w_load  = 1'b1;
        if (model) mw = nw;
        tick();
        bus.w_load = 1'b0;
    endtask

    task automatic send(input bit last, input int gap);
        bus.activation = av;
        bus.q_shift    = sv;
        bus.a_last     = last;
        bus.a_valid    = 1'b1;
        tick();
        bus.a_valid = 1'b0;
        bus.a_last  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 8 * LAT + 20; k++) begin
            if (!draining) break;
            tick();
        end
        check("drained", draining, 0);
        tick();
    endtask

    task automatic rand_w();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) nw[i][j] = DW'($urandom);
    endtask

    task automatic rand_v();
        for (int i = 0; i < N; i++) av[i] = DW'($urandom);
        sv = 5'($urandom_range(0, 20));
    endtask

    task automatic fill_w(input int v, input bit ident);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) nw[i][j] = ident ? DW'(i == j) : DW'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mw[i][j] = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_a_ready"}, bus.a_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_done"}, bus.done, 0);
        for (int j = 0; j < N; j++) begin
            check({tag, "_raw"}, bus.result_raw[j], 0);
            check({tag, "_q"}, bus.result_q[j], 0);
        end
    endtask

    task automatic ident_stream(input string tag);
        fill_w(0, 1);
        load_w(1);
        for (int i = 0; i < N; i++) av[i] = DW'(i + 1);
        sv = 5'd0;
        send(1, 0);
        wait_drain();
        for (int j = 0; j < N; j++) begin
            check({tag, "_raw"}, bus.result_raw[j], j + 1);
            check({tag, "_q"}, bus.result_q[j], j + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.w_load  = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_last  = 1'b0;
        bus.q_shift = '0;
        for (int i = 0; i < N; i++) begin
            bus.activation[i] = '0;
            for (int j = 0; j < N; j++) bus.weights[i][j] = '0;
        end
        for (int j = 0; j < N; j++) begin
            hold_raw[j] = 0;
            hold_q[j]   = 0;
        end
        do_reset();
        mon_en = 1;
        check_idle_zero("reset");

        ident_stream("ident");

        fill_w(127, 0);
        load_w(1);
        for (int i = 0; i < N; i++) av[i] = 8'sd127;
        sv = 5'd0;
        send(1, 0);
        wait_drain();
        check("max_raw", bus.result_raw[2], 64516);
        check("max_q", bus.result_q[2], 127);
        for (int i = 0; i < N; i++) av[i] = -8'sd128;
        send(1, 0);
        wait_drain();
        check("min_raw", bus.result_raw[1], -65024);
        check("min_q", bus.result_q[1], -128);

        fill_w(0, 0);
        nw[0][0] = 8'sd5;
        load_w(1);
        for (int i = 0; i < N; i++) av[i] = '0;
        av[0] = 8'sd1;
        sv = 5'd1;
        send(1, 0);
        wait_drain();
        check("round_pos_q", bus.result_q[0], 3);
        av[0] = -8'sd1;
        send(1, 0);
        wait_drain();
        check("round_neg_q", bus.result_q[0], -2);

        rand_w();
        load_w(1);
        for (int k = 0; k < 10; k++) begin
            rand_v();
            send(k == 9, 0);
        end
        wait_drain();

        rand_w();
        load_w(1);
        for (int k = 0; k < 8; k++) begin
            rand_v();
            send(k == 7, $urandom_range(0, 2));
        end
        wait_drain();

        rand_w();
        load_w(1);
        for (int k = 0; k < 6; k++) begin
            rand_v();
            if (k == 2) begin
                rand_w();
                bus.weights = nw;
                bus.w_load  = 1'b1;
            end
            send(k == 5, 0);
            bus.w_load = 1'b0;
        end
        wait_drain();
        load_w(1);
        for (int k = 0; k < 3; k++) begin
            rand_v();
            send(k == 2, 0);
        end
        wait_drain();

        rand_w();
        load_w(1);
        for (int k = 0; k < 3; k++) begin
            rand_v();
            send(0, 0);
        end
        do_reset();
        check_idle_zero("mid_reset");
        repeat (3 * LAT) tick();
        check("post_reset_busy", bus.busy, 0);
        ident_stream("fresh");

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
